noc_vc_input_unit: RTL and testbench
====================================

# noc_vc_input_unit

Per-port virtual-channel input unit for the mesh router. It accepts flits tagged with a VC index from an upstream link and stores them in per-VC FIFOs. It tracks wormhole packet state per VC and forwards flits to the switch stage through a round-robin, stall-stable output. Each dequeue returns one credit upstream. It generalises the fixed VC/depth router settings into a parametrised buffer stage.

## Interface
- FLIT_W, 64, flit width in bits; top 2 bits are the flit-type field
- VC_NUM, 4, number of virtual channels (≥1)
- FIFO_DEPTH, 4, flits per VC FIFO (power of two, ≥2)
- VC_W, $clog2(VC_NUM) (min 1), derived VC index width
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  upstream flit present this cycle
- in_vc  in  VC_W  target VC of incoming flit
- in_flit  in  FLIT_W  incoming flit
- out_valid  out  1  a flit is offered to the switch
- out_vc  out  VC_W  VC of offered flit
- out_flit  out  FLIT_W  offered flit
- out_ready  in  1  switch accepts offered flit
- credit_valid  out  1  one-cycle credit-return pulse
- credit_vc  out  VC_W  VC whose slot was freed
- err_ovf  out  VC_NUM  sticky per-VC overflow flags
- err_proto  out  VC_NUM  sticky per-VC packet-protocol error flags

## Operation
- Flit type from in_flit[FLIT_W-1:FLIT_W-2]: 2'b10 HEAD, 2'b00 BODY, 2'b01 TAIL, 2'b11 SINGLE.
- Write: in_valid=1 stores in_flit in FIFO[in_vc]. No ready signal exists; upstream is credit-controlled.
  - Write to a full FIFO is dropped and sets err_ovf[in_vc].
  - Exception: a write to a full FIFO in the same cycle that VC is dequeued is accepted; the count stays at DEPTH.
- in_vc ≥ VC_NUM: the flit is dropped with no flag.
- Per-VC packet FSM, advanced on accepted writes:
  - IDLE --HEAD--> ACTIVE.
  - ACTIVE --TAIL--> IDLE.
  - SINGLE and BODY/TAIL stay in their legal state: SINGLE legal only in IDLE, BODY only in ACTIVE.
  - Illegal type: sets err_proto[vc]. The flit is still stored, and the state moves as if legal (HEAD→ACTIVE, TAIL→IDLE, others unchanged).
- Output arbitration, round-robin over non-empty VCs:
  - Search starts at last_grant+1, modulo VC_NUM.
  - last_grant updates only on handshake (out_valid & out_ready).
  - VCs interleave per flit.
- Stall stability: while out_valid=1 and out_ready=0, the grant is frozen; out_vc and out_flit hold.
- Credit: each handshake produces credit_valid=1 with credit_vc = the dequeued VC, in the next cycle.

## Timing
- Reset values:
  - All FIFOs empty, all FSMs IDLE, last_grant = VC_NUM-1 (so VC0 wins first).
  - out_valid=0, out_vc=0, out_flit=0 (data is don't-care but must be driven 0 at reset).
  - credit_valid=0, credit_vc=0, err_ovf=0, err_proto=0.
- Reset asserted mid-packet: all state clears immediately. Credits for flits in flight are not returned.
- Write-to-offer latency: a flit written in cycle N may appear on out_valid in cycle N+1. No same-cycle bypass.
- Output is a combinational read of the granted FIFO head plus a registered grant lock. Back-to-back handshakes give 1 flit/cycle.
- Credit latency: handshake in cycle N gives credit_valid in cycle N+1, for exactly 1 cycle per flit.
- Pointers wrap modulo FIFO_DEPTH. Count width is $clog2(FIFO_DEPTH)+1.
- Error flags clear only on reset.

## Configuration
- NOC_VC_PROTO_CHECK_EN
  - Defined: per-VC packet FSMs and err_proto logic are present.
  - Undefined: FSMs are removed, err_proto is tied to 0, and flit types are ignored for checking.
- Data path, arbitration, credits and err_ovf are identical in both builds.

## Structure
- Shared package Noc_parameters gains:
  - typedef enum logic [1:0] e_flit_type {FLIT_BODY, FLIT_TAIL, FLIT_HEAD, FLIT_SINGLE}, encoded 00/01/10/11.
  - typedef enum logic {VC_IDLE, VC_ACTIVE} e_vc_state.
  - localparam Noc_Flit_Type_Msb = 2, the type-field width.
- One sub-module, noc_vc_fifo: single FIFO with count output, instantiated VC_NUM times via generate.
- Arbiter and FSMs live in the top.

## Test plan
- Reset, then HEAD,BODY,TAIL on VC1, out_ready=1:
  - Flits exit in order on cycles 1-3 after each write.
  - credit_valid pulses with credit_vc=1 three times.
  - err_proto=0.
- VC0 and VC2 both hold 2 flits, out_ready=1 → output order VC0,VC2,VC0,VC2.
- out_ready=0 for 3 cycles while VC3 arrives during the stall → out_vc and out_flit stay unchanged, and no credit is returned until the handshake.
- Fill VC0 with 4 flits, out_ready=0, write a 5th → 5th is dropped and err_ovf=4'b0001.
  - Repeat with a full VC and out_ready=1 in the same cycle → write is accepted and count stays 4.
- BODY on IDLE VC2 → err_proto=4'b0100.
  - With NOC_VC_PROTO_CHECK_EN undefined, the same stimulus leaves err_proto=0.
- Assert rst_n low mid-packet with 3 flits buffered → outputs take reset values asynchronously. After release, a HEAD on the same VC raises no error.

Source files
------------

// File: rtl/Noc_parameters.sv
// Shared NoC definitions: flit-type encoding, per-VC packet state and the
// width of the flit-type field carried in the top bits of every flit.
package Noc_parameters;

   localparam int Noc_Flit_Type_Msb = 2;

   typedef enum logic [1:0] {
      FLIT_BODY   = 2'b00,
      FLIT_TAIL   = 2'b01,
      FLIT_HEAD   = 2'b10,
      FLIT_SINGLE = 2'b11
   } e_flit_type;

   typedef enum logic {
      VC_IDLE   = 1'b0,
      VC_ACTIVE = 1'b1
   } e_vc_state;

endpackage

// File: rtl/noc_vc_input_unit_fifo.sv
// noc_vc_fifo: single-VC flit FIFO with occupancy count. The caller only
// asserts pop when the FIFO is non-empty and push when a slot is (or is
// being) freed, so no internal guarding is needed.
module noc_vc_fifo #(
   parameter int W     = 64,
   parameter int DEPTH = 4,
   parameter int CNT_W = $clog2(DEPTH) + 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  logic             pop,
   input  logic [W-1:0]     wr_data,
   output logic [W-1:0]     rd_data,
   output logic [CNT_W-1:0] count
);
   localparam int PTR_W = $clog2(DEPTH);

   logic [W-1:0]     mem_q [DEPTH];
   logic [W-1:0]     mem_d [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;

   assign rd_data = mem_q[rd_ptr_q];
   assign count   = count_q;

   // Next-state: pointers wrap naturally since DEPTH is a power of two.
   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (push) begin
         mem_d[wr_ptr_q] = wr_data;
         wr_ptr_d        = wr_ptr_q + 1'b1;
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + 1'b1;
      end
      count_d = count_q + CNT_W'(push) - CNT_W'(pop);
   end

   // State registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         mem_q    <= mem_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

endmodule

// File: rtl/noc_vc_input_unit.sv
// noc_vc_input_unit: per-port VC input buffer with round-robin, stall-stable
// output and one credit per dequeue.
// Build option: NOC_VC_PROTO_CHECK_EN adds per-VC wormhole packet FSMs and
// err_proto; without it err_proto is tied low.
//
// Packet FSM (per VC, advanced on accepted writes)
//   state     | meaning
//   VC_IDLE   | between packets; HEAD or SINGLE expected
//   VC_ACTIVE | inside a packet; BODY or TAIL expected
module noc_vc_input_unit
   import Noc_parameters::*;
#(
   parameter int FLIT_W     = 64,
   parameter int VC_NUM     = 4,
   parameter int FIFO_DEPTH = 4,
   parameter int VC_W       = (VC_NUM > 1) ? $clog2(VC_NUM) : 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   input  logic [VC_W-1:0]   in_vc,
   input  logic [FLIT_W-1:0] in_flit,
   output logic              out_valid,
   output logic [VC_W-1:0]   out_vc,
   output logic [FLIT_W-1:0] out_flit,
   input  logic              out_ready,
   output logic              credit_valid,
   output logic [VC_W-1:0]   credit_vc,
   output logic [VC_NUM-1:0] err_ovf,
   output logic [VC_NUM-1:0] err_proto
);
   localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

   logic [CNT_W-1:0]  fifo_cnt  [VC_NUM];
   logic [FLIT_W-1:0] fifo_head [VC_NUM];
   logic [VC_NUM-1:0] fifo_push, fifo_pop, vc_full, vc_nonempty;

   logic              in_vc_ok, hs, rr_found;
   logic [VC_W-1:0]   rr_vc;
   logic              lock_q, lock_d;
   logic [VC_W-1:0]   grant_q, grant_d, last_grant_q, last_grant_d;
   logic              credit_valid_q, credit_valid_d;
   logic [VC_W-1:0]   credit_vc_q, credit_vc_d;
   logic [VC_NUM-1:0] err_ovf_q, err_ovf_d;

   assign in_vc_ok = ({1'b0, in_vc} < (VC_W+1)'(VC_NUM));

   for (genvar g = 0; g < VC_NUM; g++) begin : g_vc
      noc_vc_fifo #(
         .W     (FLIT_W),
         .DEPTH (FIFO_DEPTH),
         .CNT_W (CNT_W)
      ) u_fifo (
         .clk     (clk),
         .rst_n   (rst_n),
         .push    (fifo_push[g]),
         .pop     (fifo_pop[g]),
         .wr_data (in_flit),
         .rd_data (fifo_head[g]),
         .count   (fifo_cnt[g])
      );
   end

   // Per-VC occupancy status derived from the FIFO counts.
   always_comb begin
      for (int v = 0; v < VC_NUM; v++) begin
         vc_full[v]     = (fifo_cnt[v] == CNT_W'(FIFO_DEPTH));
         vc_nonempty[v] = (fifo_cnt[v] != '0);
      end
   end

   // Round-robin search over non-empty VCs starting after last_grant.
   always_comb begin
      logic [VC_W-1:0] idx;
      rr_vc    = '0;
      rr_found = 1'b0;
      for (int i = 1; i <= VC_NUM; i++) begin
         idx = VC_W'((int'(last_grant_q) + i) % VC_NUM);
         if (!rr_found && vc_nonempty[idx]) begin
            rr_found = 1'b1;
            rr_vc    = idx;
         end
      end
   end

   // A stalled offer keeps its VC; that VC cannot drain meanwhile, so its head holds.
   assign out_valid = lock_q | rr_found;
   assign out_vc    = lock_q ? grant_q : rr_vc;
   assign out_flit  = out_valid ? fifo_head[out_vc] : '0;
   assign hs        = out_valid & out_ready;

   // Write acceptance, dequeue, grant lock and credit generation.
   always_comb begin
      fifo_push = '0;
      fifo_pop  = '0;
      err_ovf_d = err_ovf_q;
      for (int v = 0; v < VC_NUM; v++) begin
         fifo_pop[v] = hs && (out_vc == VC_W'(v));
      end
      if (in_valid && in_vc_ok) begin
         if (!vc_full[in_vc] || fifo_pop[in_vc]) fifo_push[in_vc] = 1'b1;
         else                                    err_ovf_d[in_vc] = 1'b1;
      end
      lock_d         = out_valid & ~out_ready;
      grant_d        = out_vc;
      last_grant_d   = hs ? out_vc : last_grant_q;
      credit_valid_d = hs;
      credit_vc_d    = hs ? out_vc : '0;
   end

   // Control registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         lock_q         <= 1'b0;
         grant_q        <= '0;
         last_grant_q   <= VC_W'(VC_NUM - 1);
         credit_valid_q <= 1'b0;
         credit_vc_q    <= '0;
         err_ovf_q      <= '0;
      end else begin
         lock_q         <= lock_d;
         grant_q        <= grant_d;
         last_grant_q   <= last_grant_d;
         credit_valid_q <= credit_valid_d;
         credit_vc_q    <= credit_vc_d;
         err_ovf_q      <= err_ovf_d;
      end
   end

   assign credit_valid = credit_valid_q;
   assign credit_vc    = credit_vc_q;
   assign err_ovf      = err_ovf_q;

`ifdef NOC_VC_PROTO_CHECK_EN
   e_vc_state         vc_state_q [VC_NUM];
   e_vc_state         vc_state_d [VC_NUM];
   logic [VC_NUM-1:0] err_proto_q, err_proto_d;
   e_flit_type        in_type;

   assign in_type = e_flit_type'(in_flit[FLIT_W-1 -: Noc_Flit_Type_Msb]);

   // Packet FSM: illegal types flag an error but the state still moves as if legal.
   always_comb begin
      err_proto_d = err_proto_q;
      for (int v = 0; v < VC_NUM; v++) begin
         vc_state_d[v] = vc_state_q[v];
         if (fifo_push[v]) begin
            case (in_type)
               FLIT_HEAD: begin
                  if (vc_state_q[v] != VC_IDLE) err_proto_d[v] = 1'b1;
                  vc_state_d[v] = VC_ACTIVE;
               end
               FLIT_TAIL: begin
                  if (vc_state_q[v] != VC_ACTIVE) err_proto_d[v] = 1'b1;
                  vc_state_d[v] = VC_IDLE;
               end
               FLIT_BODY:   if (vc_state_q[v] != VC_ACTIVE) err_proto_d[v] = 1'b1;
               FLIT_SINGLE: if (vc_state_q[v] != VC_IDLE)   err_proto_d[v] = 1'b1;
               default: ;
            endcase
         end
      end
   end

   // Packet FSM registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int v = 0; v < VC_NUM; v++) vc_state_q[v] <= VC_IDLE;
         err_proto_q <= '0;
      end else begin
         vc_state_q  <= vc_state_d;
         err_proto_q <= err_proto_d;
      end
   end

   assign err_proto = err_proto_q;
`else
   assign err_proto = '0;
`endif

endmodule

// File: tb/tb_noc_vc_input_unit.sv
// Directed scoreboard bench for noc_vc_input_unit (default parameters).
module tb_noc_vc_input_unit;
   localparam logic [1:0] T_BODY = 2'b00, T_TAIL = 2'b01, T_HEAD = 2'b10, T_SINGLE = 2'b11;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        in_valid = 1'b0;
   logic [1:0]  in_vc = '0;
   logic [63:0] in_flit = '0;
   logic        out_valid;
   logic [1:0]  out_vc;
   logic [63:0] out_flit;
   logic        out_ready = 1'b0;
   logic        credit_valid;
   logic [1:0]  credit_vc;
   logic [3:0]  err_ovf, err_proto;

   typedef struct packed {
      logic [1:0]  vc;
      logic [63:0] flit;
   } exp_t;

   exp_t exp_q[$];
   exp_t e;
   int   checks = 0;
   int   errors = 0;
   logic pend_hs = 1'b0;
   logic [1:0] pend_vc = '0;

   noc_vc_input_unit dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .in_valid     (in_valid),
      .in_vc        (in_vc),
      .in_flit      (in_flit),
      .out_valid    (out_valid),
      .out_vc       (out_vc),
      .out_flit     (out_flit),
      .out_ready    (out_ready),
      .credit_valid (credit_valid),
      .credit_vc    (credit_vc),
      .err_ovf      (err_ovf),
      .err_proto    (err_proto)
   );

   always #5 clk = ~clk;

   function automatic logic [63:0] mk(input logic [1:0] t, input int p);
      return {t, 62'(p)};
   endfunction

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      assert (got === exp)
      else begin
         errors++;
         $error("FAIL %s got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic wr(input logic [1:0] vc, input logic [63:0] f);
      in_valid = 1'b1;
      in_vc    = vc;
      in_flit  = f;
      cyc();
      in_valid = 1'b0;
   endtask

   task automatic push_exp(input logic [1:0] vc, input logic [63:0] f);
      exp_t x;
      x.vc   = vc;
      x.flit = f;
      exp_q.push_back(x);
   endtask

   task automatic do_reset();
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      exp_q.delete();
      rst_n = 1'b1;
   endtask

   task automatic drain(input string tag);
      for (int i = 0; i < 50 && exp_q.size() > 0; i++) @(posedge clk);
      #1;
      checks++;
      assert (exp_q.size() == 0)
      else begin
         errors++;
         $error("FAIL %s_timeout got %0d pending expected 0", tag, exp_q.size());
      end
      chk({tag, "_idle"}, 64'(out_valid), 64'(0));
   endtask

   // Monitor: credit one cycle after each handshake, flits in scoreboard order.
   always @(negedge clk) begin
      if (!rst_n) begin
         pend_hs = 1'b0;
      end else begin
         chk("credit_valid", 64'(credit_valid), 64'(pend_hs));
         if (pend_hs) chk("credit_vc", 64'(credit_vc), 64'(pend_vc));
         pend_hs = out_valid & out_ready;
         pend_vc = out_vc;
         if (out_valid && out_ready) begin
            checks++;
            assert (exp_q.size() > 0)
            else begin
               errors++;
               $error("FAIL unexpected_out got vc %0d flit %h expected none", out_vc, out_flit);
            end
            if (exp_q.size() > 0) begin
               e = exp_q.pop_front();
               chk("out_vc", 64'(out_vc), 64'(e.vc));
               chk("out_flit", out_flit, e.flit);
            end
         end
      end
   end

   initial begin
      logic [63:0] f0;
      // Reset values
      #2;
      chk("rst_out_valid", 64'(out_valid), 64'(0));
      chk("rst_out_vc", 64'(out_vc), 64'(0));
      chk("rst_out_flit", out_flit, 64'(0));
      chk("rst_credit_valid", 64'(credit_valid), 64'(0));
      chk("rst_credit_vc", 64'(credit_vc), 64'(0));
      chk("rst_err_ovf", 64'(err_ovf), 64'(0));
      chk("rst_err_proto", 64'(err_proto), 64'(0));
      do_reset();

      // HEAD, BODY, TAIL on VC1 with out_ready=1: one-cycle latency each
      out_ready = 1'b1;
      push_exp(2'd1, mk(T_HEAD, 'h101));
      wr(2'd1, mk(T_HEAD, 'h101));
      chk("t1_lat_h", out_flit, mk(T_HEAD, 'h101));
      push_exp(2'd1, mk(T_BODY, 'h102));
      wr(2'd1, mk(T_BODY, 'h102));
      chk("t1_lat_b", out_flit, mk(T_BODY, 'h102));
      push_exp(2'd1, mk(T_TAIL, 'h103));
      wr(2'd1, mk(T_TAIL, 'h103));
      chk("t1_lat_t", out_flit, mk(T_TAIL, 'h103));
      drain("t1");
      chk("t1_err_proto", 64'(err_proto), 64'(0));

      // VC0 and VC2 two flits each: interleaved VC0,VC2,VC0,VC2
      do_reset();
      wr(2'd0, mk(T_SINGLE, 'h201));
      wr(2'd0, mk(T_SINGLE, 'h202));
      wr(2'd2, mk(T_SINGLE, 'h221));
      wr(2'd2, mk(T_SINGLE, 'h222));
      push_exp(2'd0, mk(T_SINGLE, 'h201));
      push_exp(2'd2, mk(T_SINGLE, 'h221));
      push_exp(2'd0, mk(T_SINGLE, 'h202));
      push_exp(2'd2, mk(T_SINGLE, 'h222));
      out_ready = 1'b1;
      drain("t2");

      // Stall for 3 cycles with VC3 arriving: offer frozen, no credit
      do_reset();
      f0 = mk(T_SINGLE, 'h301);
      push_exp(2'd0, f0);
      wr(2'd0, f0);
      push_exp(2'd3, mk(T_SINGLE, 'h331));
      for (int i = 0; i < 3; i++) begin
         if (i == 0) wr(2'd3, mk(T_SINGLE, 'h331));
         else        cyc();
         chk("t3_stall_valid", 64'(out_valid), 64'(1));
         chk("t3_stall_vc", 64'(out_vc), 64'(0));
         chk("t3_stall_flit", out_flit, f0);
         chk("t3_stall_credit", 64'(credit_valid), 64'(0));
      end
      out_ready = 1'b1;
      drain("t3");

      // Overflow: 5th write to full VC0 dropped; write during dequeue accepted
      do_reset();
      for (int i = 0; i < 4; i++) begin
         push_exp(2'd0, mk(T_SINGLE, 'h400 + i));
         wr(2'd0, mk(T_SINGLE, 'h400 + i));
      end
      wr(2'd0, mk(T_SINGLE, 'h404));
      chk("t4_err_ovf", 64'(err_ovf), 64'(4'b0001));
      out_ready = 1'b1;
      push_exp(2'd0, mk(T_SINGLE, 'h405));
      wr(2'd0, mk(T_SINGLE, 'h405));
      chk("t4_full_deq_valid", 64'(out_valid), 64'(1));
      drain("t4");
      chk("t4_err_ovf_hold", 64'(err_ovf), 64'(4'b0001));

      // BODY on idle VC2
      do_reset();
      push_exp(2'd2, mk(T_BODY, 'h521));
      wr(2'd2, mk(T_BODY, 'h521));
`ifdef NOC_VC_PROTO_CHECK_EN
      chk("t5_err_proto", 64'(err_proto), 64'(4'b0100));
`else
      chk("t5_err_proto", 64'(err_proto), 64'(4'b0000));
`endif
      out_ready = 1'b1;
      drain("t5");

      // Reset mid-packet with 3 flits buffered and a credit pending
      do_reset();
      push_exp(2'd1, mk(T_HEAD, 'h611));
      push_exp(2'd1, mk(T_BODY, 'h612));
      push_exp(2'd1, mk(T_BODY, 'h613));
      wr(2'd1, mk(T_HEAD, 'h611));
      wr(2'd1, mk(T_BODY, 'h612));
      wr(2'd1, mk(T_BODY, 'h613));
      out_ready = 1'b1;
      cyc();
      chk("t6_credit_before", 64'(credit_valid), 64'(1));
      rst_n = 1'b0;
      #1;
      chk("t6_rst_valid", 64'(out_valid), 64'(0));
      chk("t6_rst_vc", 64'(out_vc), 64'(0));
      chk("t6_rst_flit", out_flit, 64'(0));
      chk("t6_rst_credit", 64'(credit_valid), 64'(0));
      chk("t6_rst_err_proto", 64'(err_proto), 64'(0));
      do_reset();
      push_exp(2'd1, mk(T_HEAD, 'h621));
      wr(2'd1, mk(T_HEAD, 'h621));
      chk("t6_head_err_proto", 64'(err_proto), 64'(0));
      out_ready = 1'b1;
      drain("t6");

      repeat (3) @(posedge clk);
      #1;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
